// File: rtl/cache_miss_ctrl_pkg.sv
// Shared constants, state encoding and address helpers for the cache miss sequencer.
package cache_miss_ctrl_pkg;

  localparam int ADR_WIDTH_DEF      = 32;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int LINE_BITS          = DATA_WIDTH_DEF * WORDS_PER_LINE_DEF;
  localparam int OFFSET_BITS        = 4;
  localparam int BEAT_BITS          = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_RF   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Word index of a byte offset inside a line; picks the critical word.
  function automatic logic [BEAT_BITS-1:0] word_of(input logic [OFFSET_BITS-1:0] byte_ofs);
    return byte_ofs[OFFSET_BITS-1:2];
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_mem_beat_ctr.sv
// Beat counter: loads a start word, advances on each ack, and flags the 4th beat
// regardless of where the burst started.
module mem_beat_ctr
  import cache_miss_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [BEAT_BITS-1:0] start_i,
  input  logic                 inc_i,
  output logic [BEAT_BITS-1:0] beat_o,
  output logic                 last_o
);

  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic [BEAT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      beat_d = start_i;
      cnt_d  = '0;
    end else if (inc_i) begin
      beat_d = beat_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: optional dirty-victim writeback, then 4-beat line refill.
// Build option CRIT_WORD_FIRST_EN starts the refill at the missing word.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_req_i,
  input  logic [ADR_WIDTH-1:0]               miss_adr_i,
  input  logic                               victim_dirty_i,
  input  logic [ADR_WIDTH-1:0]               victim_adr_i,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] victim_dat_i,
  output logic                               busy_o,
  output logic                               miss_done_o,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] refill_line_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [ADR_WIDTH-1:0]               mem_adr_o,
  output logic [DATA_WIDTH-1:0]              mem_dat_o,
  input  logic                               mem_ack_i,
  input  logic [DATA_WIDTH-1:0]              mem_dat_i
);

  localparam int TAG_W = ADR_WIDTH - OFFSET_BITS;
  localparam int LW    = DATA_WIDTH * WORDS_PER_LINE;

  logic [1:0]           state_q, state_d;
  logic [TAG_W-1:0]     miss_tag_q, vic_tag_q;
  logic [LW-1:0]        vic_dat_q;
  logic [LW-1:0]        line_q, line_d;
  logic [BEAT_BITS-1:0] rf_start_q, rf_start_d;
  logic                 capture;
  logic                 ack_v;
  logic                 ctr_load;
  logic [BEAT_BITS-1:0] ctr_start;
  logic [BEAT_BITS-1:0] beat;
  logic                 last_beat;
  logic                 unused_adr_bits;

`ifdef CRIT_WORD_FIRST_EN
  assign rf_start_d      = word_of(miss_adr_i[OFFSET_BITS-1:0]);
  assign unused_adr_bits = ^{miss_adr_i[1:0], victim_adr_i[OFFSET_BITS-1:0]};
`else
  assign rf_start_d      = '0;
  assign unused_adr_bits = ^{miss_adr_i[OFFSET_BITS-1:0], victim_adr_i[OFFSET_BITS-1:0]};
`endif

  assign capture = (state_q == ST_IDLE) && miss_req_i;
  assign ack_v   = mem_ack_i && mem_req_o;

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    ctr_load  = 1'b0;
    ctr_start = '0;
    case (state_q)
      ST_IDLE: begin
        if (miss_req_i) begin
          ctr_load  = 1'b1;
          ctr_start = victim_dirty_i ? '0 : rf_start_d;
          state_d   = victim_dirty_i ? ST_WB : ST_RF;
        end
      end
      ST_WB: begin
        if (ack_v && last_beat) begin
          ctr_load  = 1'b1;
          ctr_start = rf_start_q;
          state_d   = ST_RF;
        end
      end
      ST_RF: begin
        if (ack_v) begin
          line_d[int'(beat)*DATA_WIDTH +: DATA_WIDTH] = mem_dat_i;
          if (last_beat) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_beat_ctr u_beat_ctr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ctr_load),
    .start_i (ctr_start),
    .inc_i   (ack_v),
    .beat_o  (beat),
    .last_o  (last_beat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      miss_tag_q <= '0;
      vic_tag_q  <= '0;
      vic_dat_q  <= '0;
      rf_start_q <= '0;
      line_q     <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      if (capture) begin
        miss_tag_q <= miss_adr_i[ADR_WIDTH-1:OFFSET_BITS];
        vic_tag_q  <= victim_adr_i[ADR_WIDTH-1:OFFSET_BITS];
        vic_dat_q  <= victim_dat_i;
        rf_start_q <= rf_start_d;
      end
    end
  end

  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    if (state_q == ST_WB) begin
      mem_req_o = 1'b1;
      mem_we_o  = 1'b1;
      mem_adr_o = {vic_tag_q, beat, 2'b00};
      mem_dat_o = vic_dat_q[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
    end else if (state_q == ST_RF) begin
      mem_req_o = 1'b1;
      mem_adr_o = {miss_tag_q, beat, 2'b00};
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign miss_done_o   = (state_q == ST_DONE);
  assign refill_line_o = line_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl; memory answers each read with 0xA0 + word index.
module tb_cache_miss_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req_i;
  logic [31:0]  miss_adr_i;
  logic         victim_dirty_i;
  logic [31:0]  victim_adr_i;
  logic [127:0] victim_dat_i;
  logic         busy_o;
  logic         miss_done_o;
  logic [127:0] refill_line_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_adr_o;
  logic [31:0]  mem_dat_o;
  logic         mem_ack_i;
  logic [31:0]  mem_dat_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] EXP_LINE = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
  localparam logic [127:0] VIC_DAT  = {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011};

  cache_miss_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_req_i     (miss_req_i),
    .miss_adr_i     (miss_adr_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_adr_i   (victim_adr_i),
    .victim_dat_i   (victim_dat_i),
    .busy_o         (busy_o),
    .miss_done_o    (miss_done_o),
    .refill_line_o  (refill_line_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_adr_o      (mem_adr_o),
    .mem_dat_o      (mem_dat_o),
    .mem_ack_i      (mem_ack_i),
    .mem_dat_i      (mem_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, miss_done_o, 0);
    check({tag, "_req"},  mem_req_o, 0);
    check({tag, "_we"},   mem_we_o, 0);
    check({tag, "_adr"},  mem_adr_o, 0);
    check({tag, "_dat"},  mem_dat_o, 0);
    check({tag, "_line"}, refill_line_o, 0);
  endtask

  // abort_k >= 0: pull reset when the burst reaches that beat index.
  task automatic run_miss(input logic [31:0] madr, input bit dirty, input logic [31:0] vadr,
                          input int stall, input bit repulse, input int abort_k,
                          input int exp_done_cyc);
    int          k, nbeats, stall_cnt, cyc, dones, w;
    logic [31:0] mbase, vbase, eadr, edat;
    logic        ewe;
    logic [1:0]  start;
    mbase  = {madr[31:4], 4'h0};
    vbase  = {vadr[31:4], 4'h0};
`ifdef CRIT_WORD_FIRST_EN
    start  = madr[3:2];
`else
    start  = 2'd0;
`endif
    nbeats = dirty ? 8 : 4;
    k = 0; dones = 0; cyc = 0; stall_cnt = 0;
    @(negedge clk);
    miss_req_i     = 1'b1;
    miss_adr_i     = madr;
    victim_dirty_i = dirty;
    victim_adr_i   = vadr;
    victim_dat_i   = VIC_DAT;
    mem_ack_i      = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      miss_req_i = repulse && (cyc == 2 || cyc == 3);
      mem_ack_i  = 1'b0;
      mem_dat_i  = 32'h0;
      if (cyc == 1) check("busy_after_req", busy_o, 1);
      if (mem_req_o) begin
        if (k >= nbeats) begin
          check("beat_overrun", mem_req_o, 0);
          break;
        end
        if (dirty && k < 4) begin
          eadr = vbase + 32'(4 * k);
          ewe  = 1'b1;
          edat = VIC_DAT[k*32 +: 32];
        end else begin
          w    = (int'(start) + (dirty ? k - 4 : k)) % 4;
          eadr = mbase + 32'(4 * w);
          ewe  = 1'b0;
          edat = 32'h0;
        end
        if (k == abort_k) begin
          miss_req_i = 1'b0;
          rst = 1'b0;
          #1;
          check_all_zero("abort");
          @(negedge clk);
          check("abort_hold_req", mem_req_o, 0);
          rst = 1'b1;
          return;
        end
        check($sformatf("adr_b%0d", k), mem_adr_o, eadr);
        check($sformatf("we_b%0d", k), mem_we_o, ewe);
        if (ewe) check($sformatf("wdat_b%0d", k), mem_dat_o, edat);
        if (stall_cnt < stall) begin
          stall_cnt++;
        end else begin
          mem_ack_i = 1'b1;
          mem_dat_i = 32'hA0 + 32'(mem_adr_o[3:2]);
          stall_cnt = 0;
          k++;
        end
      end else begin
        mem_ack_i = (stall > 0);
        mem_dat_i = 32'hDEADBEEF;
      end
      if (miss_done_o) begin
        dones++;
        check("done_line", refill_line_o, EXP_LINE);
        check("done_beats", k, nbeats);
        if (exp_done_cyc > 0) check("done_cycle", cyc, exp_done_cyc);
      end
      if (!busy_o && cyc > 1) break;
    end
    miss_req_i = 1'b0;
    mem_ack_i  = 1'b0;
    check("no_timeout", (cyc < 200), 1);
    check("done_count", dones, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", busy_o, 0);
      check("idle_done", miss_done_o, 0);
      check("idle_req", mem_req_o, 0);
    end
    check("line_hold", refill_line_o, EXP_LINE);
  endtask

  initial begin
    rst            = 1'b0;
    miss_req_i     = 1'b0;
    miss_adr_i     = '0;
    victim_dirty_i = 1'b0;
    victim_adr_i   = '0;
    victim_dat_i   = '0;
    mem_ack_i      = 1'b0;
    mem_dat_i      = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // clean miss, ack every cycle: DONE on cycle 5
    run_miss(32'h00CC3B43, 1'b0, 32'h0, 0, 1'b0, -1, 5);
    // dirty miss: 4 writes then 4 reads, DONE on cycle 9
    run_miss(32'h00CC3B43, 1'b1, 32'h00CC3340, 0, 1'b0, -1, 9);
    // 3-cycle stall per beat: DONE on cycle 17, stray acks while idle
    run_miss(32'h00CC3B40, 1'b0, 32'h0, 3, 1'b0, -1, 17);
    // dirty miss with stalls and a repeated request while busy
    run_miss(32'h00CC3B4C, 1'b1, 32'h00CC3340, 1, 1'b1, -1, 0);
    // reset during the third refill beat, then a clean miss from scratch
    run_miss(32'h00CC3B43, 1'b0, 32'h0, 0, 1'b0, 2, 0);
    check_all_zero("after_abort");
    run_miss(32'h00CC3B43, 1'b0, 32'h0, 0, 1'b0, -1, 5);
    // critical word in the middle of the line
    run_miss(32'h00CC3B48, 1'b0, 32'h0, 0, 1'b0, -1, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Miss-handling sequencer for the 4-way cache. It owns the single word-wide memory port (mem_req_o/mem_ack_i) and shares it between dirty-victim writeback and line refill. On a cache miss it optionally writes the victim line back, then fetches the 4-word missing line, and returns it to the cache as one 128-bit line. It sits between the cache4way tag/data arrays and the memory bus.

Parameters:
ADR_WIDTH, 32, byte address width
DATA_WIDTH, 32, memory beat width
WORDS_PER_LINE, 4, beats per line; fixed power of two; line = 128 bits at defaults

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
miss_req_i  in  1  cache requests miss service; sampled only in IDLE
miss_adr_i  in  ADR_WIDTH  missing address (any byte in line)
victim_dirty_i  in  1  victim line must be written back; sampled with miss_req_i
victim_adr_i  in  ADR_WIDTH  victim line address
victim_dat_i  in  DATA_WIDTH*WORDS_PER_LINE  victim line data; word 0 in LSBs
busy_o  out  1  controller not in IDLE
miss_done_o  out  1  one-cycle pulse: refill_line_o valid
refill_line_o  out  DATA_WIDTH*WORDS_PER_LINE  assembled refill line
mem_req_o  out  1  memory beat request
mem_we_o  out  1  1 = write beat, 0 = read beat
mem_adr_o  out  ADR_WIDTH  beat word address
mem_dat_o  out  DATA_WIDTH  write beat data
mem_ack_i  in  1  beat complete; read data valid same cycle
mem_dat_i  in  DATA_WIDTH  read beat data

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; beat counter 0; line buffer 0.
- States: IDLE, WB, RF, DONE.
- IDLE: miss_req_i=1 at edge -> latch line addresses {adr[ADR_WIDTH-1:4],4'b0} and victim data; go WB if victim_dirty_i else RF. busy_o=1 from next cycle.
- WB: mem_req_o=1, mem_we_o=1, mem_adr_o={victim line, beat, 2'b00}, mem_dat_o=victim word[beat]. On mem_ack_i: beat++; after beat 3 ack -> RF, beat=start.
- RF: mem_req_o=1, mem_we_o=0, mem_adr_o={miss line, beat, 2'b00}. On mem_ack_i: line buffer word[beat]<=mem_dat_i, beat++ (mod 4); after 4th ack -> DONE.
- DONE: miss_done_o=1 for exactly one cycle, refill_line_o stable; -> IDLE. refill_line_o holds until next refill writes.
- Request/address/data held stable while mem_req_o=1 and no ack; mem_ack_i with mem_req_o=0 ignored.
- Back-to-back acks: one beat per cycle; mem_req_o stays high across WB->RF transition (no bubble required, one allowed).
- miss_req_i while busy_o=1 ignored; cache must hold it until IDLE.
- Min latency, clean miss, ack every cycle: req edge -> 4 RF cycles -> DONE pulse on cycle 5.
- Beat counter 2-bit, wraps 3->0.
- Reset mid-burst: abandon immediately, no further mem_req_o, partial line discarded.

Optional Feature:
CRIT_WORD_FIRST_EN: defined -> RF starts at beat = miss_adr_i[3:2] and wraps (e.g. 2,3,0,1); words placed by index so refill_line_o identical. Undefined -> RF always starts at beat 0. WB always starts at 0.

Decomposition:
- cache_pkg: state encoding, LINE_BITS=DATA_WIDTH*WORDS_PER_LINE, OFFSET_BITS=4, BEAT_BITS=2, line-address helper.
- One sub-module natural: mem_beat_ctr (load start beat, increment on ack, last-beat flag after 4 acks independent of start).

Test Plan:
- Clean read miss, miss_adr_i=0x00CC3B43, ack every cycle, mem returns 0xA0..0xA3 -> addrs 0x00CC3B40/44/48/4C, mem_we_o=0, DONE pulse with line 0x000000A3_000000A2_000000A1_000000A0.
- Dirty miss, victim_adr_i=0x00CC3340, victim data words 0x11..0x44 -> 4 writes to 0x00CC3340..4C with 0x11,0x22,0x33,0x44, then 4 reads of miss line, one DONE pulse.
- Ack stalls of 3 cycles per beat -> mem_req_o/adr/dat stable throughout; DONE after 16+ cycles; no duplicate beats.
- miss_req_i pulsed again while busy -> ignored; exactly one DONE; busy_o low only after DONE.
- rst low during beat 2 of RF -> all outputs 0 immediately; next miss starts clean at beat 0.
- CRIT_WORD_FIRST_EN with miss_adr_i=0x00CC3B48 -> read order 0x...48,4C,40,44; refill_line_o same as ordered case.
